change_dispenser: RTL

//  Sequential, parametrised change machine. Accepts a cost/paid request, then dispenses change one coin
//  per handshake from a tracked quarter/dime/nickel inventory, largest coin first. Sits between the

---
 rtl/change_dispenser.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Change machine: accepts a cost/paid request and dispenses change one coin per handshake,
// largest coin first, from a saturating quarter/dime/nickel inventory (amounts in nickel units).
module change_dispenser #(
  parameter int AMT_W     = 8,
  parameter int CNT_W     = 4,
  parameter int MAX_COINS = 0,
  parameter int INIT_Q    = 3,
  parameter int INIT_D    = 3,
  parameter int INIT_N    = 3
) (
  input  logic             clock,
  input  logic             reset_N,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [AMT_W-1:0] cost,
  input  logic [AMT_W-1:0] paid,
  input  logic             refill_valid,
  input  logic [CNT_W-1:0] refill_q,
  input  logic [CNT_W-1:0] refill_d,
  input  logic [CNT_W-1:0] refill_n,
  output logic             coin_valid,
  input  logic             coin_ready,
  output logic [1:0]       coin,
  output logic             done,
  output logic             exact_amount,
  output logic             cough_up_more,
  output logic             short_change,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] inv_q,
  output logic [CNT_W-1:0] inv_d,
  output logic [CNT_W-1:0] inv_n
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DISP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [31:0] MAX_C  = 32'(MAX_COINS);

  logic [1:0]       state_q, state_d;
  logic [AMT_W-1:0] cost_q, cost_d, paid_q, paid_d;
  logic [AMT_W-1:0] change_q, change_d, cnt_q, cnt_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] qcnt_q, qcnt_d, dcnt_q, dcnt_d, ncnt_q, ncnt_d;
  logic             exact_q, exact_d, more_q, more_d, short_q, short_d;

  logic [1:0] sel;
  logic [2:0] sel_val;
  logic       cap_ok, offer, accept;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Greedy selection depends only on registered state, so coin_ready never reaches coin/coin_valid
  always_comb begin
    sel     = 2'b00;
    sel_val = 3'd0;
    if (change_q >= AMT_W'(5) && qcnt_q != '0) begin
      sel     = 2'b11;
      sel_val = 3'd5;
    end else if (change_q >= AMT_W'(2) && dcnt_q != '0) begin
      sel     = 2'b10;
      sel_val = 3'd2;
    end else if (change_q != '0 && ncnt_q != '0) begin
      sel     = 2'b01;
      sel_val = 3'd1;
    end
  end

  assign cap_ok = (MAX_C == 32'd0) || (32'(cnt_q) < MAX_C);
  assign offer  = (state_q == S_DISP) && (sel != 2'b00) && (change_q != '0) && cap_ok;
  assign accept = offer && coin_ready;

  always_comb begin
    state_d  = state_q;
    cost_d   = cost_q;
    paid_d   = paid_q;
    change_d = change_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    qcnt_d   = qcnt_q;
    dcnt_d   = dcnt_q;
    ncnt_d   = ncnt_q;
    exact_d  = exact_q;
    more_d   = more_q;
    short_d  = short_q;
    case (state_q)
      S_IDLE: begin
        if (refill_valid) begin
          qcnt_d = sat_add(qcnt_q, refill_q);
          dcnt_d = sat_add(dcnt_q, refill_d);
          ncnt_d = sat_add(ncnt_q, refill_n);
        end
        if (load_valid) begin
          cost_d  = cost;
          paid_d  = paid;
          cnt_d   = '0;
          rem_d   = '0;
          exact_d = 1'b0;
          more_d  = 1'b0;
          short_d = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        change_d = '0;
        if (cost_q > paid_q) begin
          more_d  = 1'b1;
          rem_d   = '0;
          state_d = S_DONE;
        end else if (cost_q == paid_q) begin
          exact_d = 1'b1;
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          change_d = paid_q - cost_q;
          state_d  = S_DISP;
        end
      end
      S_DISP: begin
        if (accept) begin
          case (sel)
            2'b11:   qcnt_d = qcnt_q - CNT_W'(1);
            2'b10:   dcnt_d = dcnt_q - CNT_W'(1);
            default: ncnt_d = ncnt_q - CNT_W'(1);
          endcase
          change_d = change_q - AMT_W'(sel_val);
          cnt_d    = cnt_q + AMT_W'(1);
        end else if (!offer) begin
          short_d = (change_q != '0);
          rem_d   = change_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q  <= S_IDLE;
      cost_q   <= '0;
      paid_q   <= '0;
      change_q <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      qcnt_q   <= CNT_W'(INIT_Q);
      dcnt_q   <= CNT_W'(INIT_D);
      ncnt_q   <= CNT_W'(INIT_N);
      exact_q  <= 1'b0;
      more_q   <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cost_q   <= cost_d;
      paid_q   <= paid_d;
      change_q <= change_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      qcnt_q   <= qcnt_d;
      dcnt_q   <= dcnt_d;
      ncnt_q   <= ncnt_d;
      exact_q  <= exact_d;
      more_q   <= more_d;
      short_q  <= short_d;
    end
  end

  assign load_ready    = (state_q == S_IDLE);
  assign coin_valid    = offer;
  assign coin          = offer ? sel : 2'b00;
  assign done          = (state_q == S_DONE);
  assign exact_amount  = exact_q;
  assign cough_up_more = more_q;
  assign short_change  = short_q;
  assign remaining     = rem_q;
  assign inv_q         = qcnt_q;
  assign inv_d         = dcnt_q;
  assign inv_n         = ncnt_q;

endmodule
